// File: rtl/parity_pkg.sv
// Shared types and the parity rule used by both the checker and the generator side.
package parity_pkg;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } chk_state_e;

  // data_xor is the XOR reduction of the data word; the error is a mismatch
  // between the total XOR (data plus parity) and the mode's required value.
  function automatic logic parity_word_err(input logic         data_xor,
                                           input logic         parity_bit,
                                           input parity_mode_e mode);
    return (data_xor ^ parity_bit) != logic'(mode);
  endfunction

endpackage

// File: rtl/parity_word_eval.sv
// Combinational parity check of one N-bit word against its parity bit and mode.
module parity_word_eval
  import parity_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]  data,
  input  logic          parity_bit,
  input  parity_mode_e  mode,
  output logic          word_err
);

  assign word_err = parity_word_err(^data, parity_bit, mode);

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming parity checker: per-word and per-frame error flags with one
// registered output stage and a saturating word-error counter.
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_FRAME = 16,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         data_in,
  input  logic                 parity_bit,
  input  logic                 in_last,
  input  logic                 odd_mode,
  input  logic                 clr_cnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         data_out,
  output logic                 word_err,
  output logic                 out_last,
  output logic                 frame_err,
  output logic                 len_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int              CNT_W    = $clog2(MAX_FRAME + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FRAME - 1);

  chk_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  parity_mode_e     mode_q;

  logic             accept;
  logic             close;
  logic             over_len;
  logic             werr_p0;
  parity_mode_e     eff_mode;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // The first word of a frame is checked with the live mode; later words use the latched one.
  assign eff_mode = (state == IDLE) ? parity_mode_e'(odd_mode) : mode_q;
  assign over_len = (cnt == CNT_LAST);
  assign close    = in_last || over_len;

  parity_word_eval #(
    .N (N)
  ) u_eval (
    .data       (data_in),
    .parity_bit (parity_bit),
    .mode       (eff_mode),
    .word_err   (werr_p0)
  );

  // Stage p0 -> p1: frame FSM, output register and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= 1'b0;
      mode_q    <= EVEN;
      out_valid <= 1'b0;
      data_out  <= '0;
      word_err  <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      len_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        data_out  <= data_in;
        word_err  <= werr_p0;
        out_last  <= close;
        len_err   <= close && !in_last;
        frame_err <= close && (acc || werr_p0 || !in_last);

        if (close) begin
          state <= IDLE;
          cnt   <= '0;
          acc   <= 1'b0;
        end else if (state == IDLE) begin
          state  <= ACTIVE;
          mode_q <= parity_mode_e'(odd_mode);
          cnt    <= CNT_W'(1);
          acc    <= werr_p0;
        end else begin
          cnt <= cnt + CNT_W'(1);
          acc <= acc || werr_p0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A clear in the same cycle as an erroneous accept leaves that one error counted.
      if (clr_cnt) begin
        err_count <= (accept && werr_p0) ? ERR_CNT_W'(1) : '0;
      end else if (accept && werr_p0) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench with a beat scoreboard for parity_stream_checker (N=8, MAX_FRAME=4, ERR_CNT_W=2).
module tb_parity_stream_checker;

  localparam int N    = 8;
  localparam int MAXF = 4;
  localparam int ECW  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready;
  logic [N-1:0]   data_in;
  logic           parity_bit, in_last, odd_mode, clr_cnt;
  logic           out_valid, out_ready;
  logic [N-1:0]   data_out;
  logic           word_err, out_last, frame_err, len_err;
  logic [ECW-1:0] err_count;

  parity_stream_checker #(
    .N         (N),
    .MAX_FRAME (MAXF),
    .ERR_CNT_W (ECW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .parity_bit (parity_bit),
    .in_last    (in_last),
    .odd_mode   (odd_mode),
    .clr_cnt    (clr_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .word_err   (word_err),
    .out_last   (out_last),
    .frame_err  (frame_err),
    .len_err    (len_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         w;
    logic         l;
    logic         f;
    logic         le;
  } beat_t;

  beat_t sb[$];

  int   checks   = 0;
  int   failures = 0;

  // reference model state
  logic m_active;
  int   m_cnt;
  logic m_acc;
  logic m_mode;
  int   m_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_active = 1'b0;
    m_cnt    = 0;
    m_acc    = 1'b0;
    m_mode   = 1'b0;
    m_errs   = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_data_out"},  data_out,  0);
    chk({tag, "_word_err"},  word_err,  0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_len_err"},   len_err,   0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  // One clock cycle: drive, check the pre-edge view, update the model, check post-edge.
  task automatic cycle(input logic v, input logic [N-1:0] d, input logic p,
                       input logic last, input logic odd, input logic clr,
                       input logic ordy, input string tag);
    logic  acc_ok, tot, eff, werr, cls;
    beat_t b;
    in_valid   = v;
    data_in    = d;
    parity_bit = p;
    in_last    = last;
    odd_mode   = odd;
    clr_cnt    = clr;
    out_ready  = ordy;
    #1;
    chk({tag, "_in_ready"}, in_ready, (sb.size() == 0) || ordy);
    acc_ok = v && ((sb.size() == 0) || ordy);
    if (sb.size() != 0) begin
      chk({tag, "_data_out"},  data_out,  sb[0].d);
      chk({tag, "_word_err"},  word_err,  sb[0].w);
      chk({tag, "_out_last"},  out_last,  sb[0].l);
      chk({tag, "_frame_err"}, frame_err, sb[0].f);
      chk({tag, "_len_err"},   len_err,   sb[0].le);
      if (ordy) void'(sb.pop_front());
    end
    werr = 1'b0;
    if (acc_ok) begin
      tot  = ($countones({d, p}) % 2) == 1;
      eff  = m_active ? m_mode : odd;
      werr = (tot != eff);
      cls  = last || (m_cnt == MAXF - 1);
      b.d  = d;
      b.w  = werr;
      b.l  = cls;
      b.le = cls && !last;
      b.f  = cls && (m_acc || werr || !last);
      sb.push_back(b);
      if (cls) begin
        m_active = 1'b0;
        m_cnt    = 0;
        m_acc    = 1'b0;
      end else begin
        if (!m_active) m_mode = odd;
        m_active = 1'b1;
        m_cnt++;
        m_acc = m_acc | werr;
      end
    end
    if (clr) m_errs = (acc_ok && werr) ? 1 : 0;
    else if (acc_ok && werr && m_errs < (1 << ECW) - 1) m_errs++;
    @(posedge clk);
    #1;
    chk({tag, "_out_valid"}, out_valid, sb.size() != 0);
    chk({tag, "_err_count"}, err_count, m_errs);
  endtask

  task automatic word(input logic [N-1:0] d, input logic p, input logic last,
                      input logic odd, input string tag);
    cycle(1'b1, d, p, last, odd, 1'b0, 1'b1, tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; parity_bit = 1'b0;
    in_last = 1'b0; odd_mode = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
    model_clear();
    #1;
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // even mode, single-word frames: good then bad
    word(8'hA5, 1'b0, 1'b1, 1'b0, "even_good");
    word(8'hA5, 1'b1, 1'b1, 1'b0, "even_bad");
    idle("drain1");

    // odd mode, and a mid-frame mode toggle that must be ignored
    word(8'h01, 1'b0, 1'b1, 1'b1, "odd_single");
    word(8'h03, 1'b1, 1'b0, 1'b1, "odd_f1");
    word(8'h07, 1'b0, 1'b0, 1'b0, "odd_f2");
    word(8'h00, 1'b1, 1'b1, 1'b0, "odd_f3");
    idle("drain2");

    // 3-word even frame with a bad middle word
    word(8'h11, 1'b0, 1'b0, 1'b0, "mid_w1");
    word(8'h11, 1'b1, 1'b0, 1'b0, "mid_w2");
    word(8'h11, 1'b0, 1'b1, 1'b0, "mid_w3");
    idle("drain3");

    // length overrun: five words without last, then close the new frame
    for (int i = 0; i < 5; i++) word(8'h00, 1'b0, 1'b0, 1'b0, $sformatf("ovr_w%0d", i + 1));
    word(8'h0F, 1'b0, 1'b1, 1'b0, "ovr_close");
    idle("drain4");

    // back-pressure: hold out_ready low for three cycles, then release
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bp_acc");
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'h5B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("bp_hold%0d", i));
    cycle(1'b1, 8'h5B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "bp_rel");
    cycle(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "bp_next");
    idle("drain5");

    // saturation of a 2-bit counter, then clear interactions
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "clr_only");
    for (int i = 0; i < 4; i++) word(8'h80, 1'b0, 1'b1, 1'b0, $sformatf("sat%0d", i));
    cycle(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "clr_with_err");
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "clr_again");

    // asynchronous reset in the middle of a frame
    word(8'h12, 1'b0, 1'b0, 1'b0, "rst_w1");
    word(8'h34, 1'b1, 1'b0, 1'b0, "rst_w2");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    word(8'h34, 1'b1, 1'b1, 1'b0, "post_rst");
    idle("drain6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_stream_checker.md
Name: parity_stream_checker

Overview:
- Streaming, parametrised successor to the team's combinational parity checker.
- Each accepted word arrives with its own parity bit and is checked in even or odd mode.
- Words are grouped into frames delimited by a last flag. The block reports per-word errors, frame errors (including frames that run over the maximum length) and a saturating error count.
- Sits between a receive deserialiser and the frame consumer. Uses a valid/ready handshake on both sides with one registered output stage.

Parameters:
- N, 8, data word width in bits (>=1).
- MAX_FRAME, 16, maximum words per frame (>=1).
- ERR_CNT_W, 16, width of the saturating word-error counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset; clears all state immediately.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- data_in  in  N  data word.
- parity_bit  in  1  transmitted parity bit for data_in.
- in_last  in  1  data_in is the final word of its frame.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the first word of each frame.
- clr_cnt  in  1  synchronous clear of err_count.
- out_valid  out  1  registered output beat valid.
- out_ready  in  1  downstream accepts the beat.
- data_out  out  N  data word passed through.
- word_err  out  1  parity error on this word.
- out_last  out  1  this beat closes a frame.
- frame_err  out  1  frame had at least one word error or a length overrun; meaningful only when out_last=1, otherwise 0.
- len_err  out  1  frame was force-closed at MAX_FRAME without in_last.
- err_count  out  ERR_CNT_W  number of word errors since reset or clear; saturates at all-ones.

Behaviour:
- Reset values: out_valid, data_out, word_err, out_last, frame_err, len_err and err_count are all 0. FSM=IDLE, word counter=0, frame accumulator=0, mode register=0.
- Acceptance: a word is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, so a full pipeline stage is allowed.
- Latency: an accepted word appears on the outputs at the next rising edge.
- Output hold: outputs hold stable while out_valid && !out_ready. out_valid drops after a handshake if no new word was accepted in that cycle.
- Parity rule: eff_mode = odd_mode when FSM=IDLE, otherwise the latched mode. word_err = (^data_in ^ parity_bit) != eff_mode. Even mode therefore requires the total XOR of data and parity to be 0; odd mode requires 1.
- FSM states:
  - IDLE: no frame in progress.
  - ACTIVE: frame in progress; mode latched, counter holds the number of words accepted so far.
- Close condition, on an accepted word: close = in_last || (cnt == MAX_FRAME-1).
  - IDLE, accept && !close -> ACTIVE: latch odd_mode, cnt=1, acc=word_err.
  - IDLE, accept && close -> IDLE: a single-word frame.
  - ACTIVE, accept && !close: cnt+1, acc |= word_err.
  - ACTIVE, accept && close -> IDLE: cnt=0, acc=0.
- Closing beat outputs: out_last=1, len_err = !in_last, frame_err = acc | word_err | len_err.
- Overrun: the word after a forced close starts a new frame. Its in_last is honoured normally.
- MAX_FRAME=1: every word closes a frame. len_err=1 whenever in_last=0.
- Mode changes: odd_mode changes mid-frame are ignored until the next frame's first word.
- err_count update per cycle:
  - clr_cnt alone: 0.
  - clr_cnt with an erroneous accept in the same cycle: 1 (the clear wins, then the new error counts).
  - Otherwise: +1 per accepted erroneous word, never wrapping past all-ones.
- Reset mid-frame: the partial frame is discarded with no closing beat. The next accepted word starts a new frame.
- Widths: the counter is $clog2(MAX_FRAME+1) bits. No arithmetic beyond the counter increments.

Decomposition:
- Shared package parity_pkg:
  - parity_mode_e (EVEN=0, ODD=1).
  - checker FSM state enum (IDLE, ACTIVE).
  - a function returning the word error given data, parity and mode, reused by the generator side.
- One natural combinational sub-module: parity_word_eval (N-wide XOR reduction plus mode compare).

Test Plan:
- N=8, even, IDLE: 0xA5 with parity 0, then 0xA5 with parity 1 (in_last=1 each) -> word_err 0 then 1; err_count 0 then 1; frame_err 0 then 1.
- Odd mode: 0x01 with parity 0, in_last=1 -> word_err=0. Toggle odd_mode to 0 mid-frame of a 3-word frame -> words still checked odd.
- 3-word frame, middle word bad -> word_err only on beat 2; beat 3 out_last=1, frame_err=1, len_err=0.
- MAX_FRAME=4, five good words, in_last never set -> beat 4 out_last=1, len_err=1, frame_err=1; beat 5 starts a new frame (out_last=0).
- out_ready held low 3 cycles with out_valid=1 -> in_ready=0, data_out/word_err stable; release -> one beat per cycle resumes, no loss or duplication.
- ERR_CNT_W=2, four bad words -> err_count=3 (saturated). clr_cnt together with a bad accept -> err_count=1. rst_n low mid-frame -> all outputs 0 and FSM=IDLE immediately.
